// File: rtl/bcd_timer_pkg.sv
// Shared encodings, digit limits and packing for the BCD countdown timer.
// Digit order in a packed word: {min_tens, min_ones, sec_tens, sec_ones}.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX     = 4'd9;

    localparam int SEC_ONES_LSB = 0;
    localparam int SEC_TENS_LSB = 4;
    localparam int MIN_ONES_LSB = 8;
    localparam int MIN_TENS_LSB = 12;

    // Clamp each digit to its legal maximum.
    function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[SEC_ONES_LSB +: 4] > ONES_MAX)
            r[SEC_ONES_LSB +: 4] = ONES_MAX;
        if (v[SEC_TENS_LSB +: 4] > SEC_TENS_MAX)
            r[SEC_TENS_LSB +: 4] = SEC_TENS_MAX;
        if (v[MIN_ONES_LSB +: 4] > ONES_MAX)
            r[MIN_ONES_LSB +: 4] = ONES_MAX;
        if (v[MIN_TENS_LSB +: 4] > MIN_TENS_MAX)
            r[MIN_TENS_LSB +: 4] = MIN_TENS_MAX;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; wraps 0 -> MAX and signals borrow.
// Load has priority over decrement.
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] q,
    output logic       borrow
);

    assign borrow = dec & (q == 4'd0);

    always_ff @(posedge clk) begin
        if (reset_p)
            q <= 4'd0;
        else if (load)
            q <= load_val;
        else if (dec)
            q <= (q == 4'd0) ? MAX : q - 4'd1;
    end

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// MM:SS countdown controller: prescaler, command FSM, four BCD digits.
// Optional BCD_COUNTDOWN_ALARM_TIMEOUT_EN auto-clears alarm after ALARM_SEC s.
module bcd_countdown_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned ALARM_SEC = 10
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        load,
    input  logic [15:0] set_value,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        alarm,
    output logic [1:0]  state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t        st;
    logic [PW-1:0] presc;
    logic          tick;
    logic          last_sec;
    logic          dig_load;
    logic [15:0]   dig_val;
    logic [4:0]    dchain;

`ifdef BCD_COUNTDOWN_ALARM_TIMEOUT_EN
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
    logic [AW-1:0] acnt;
`endif

    assign tick     = (presc == TICK_LAST);
    assign last_sec = (digits == 16'h0001);
    assign dig_load = clear | ((st == IDLE) & load);
    assign dig_val  = clear ? 16'h0000 : bcd_sanitize(set_value);
    assign dchain[0] = (st == RUN) & tick;
    assign state    = st;

    for (genvar i = 0; i < 4; i++) begin : g_dig
        localparam logic [3:0] DMAX =
            (i == 1) ? SEC_TENS_MAX :
            (i == 3) ? MIN_TENS_MAX : ONES_MAX;
        bcd_digit_down #(.MAX(DMAX)) u_dig (
            .clk      (clk),
            .reset_p  (reset_p),
            .load     (dig_load),
            .load_val (dig_val[4*i +: 4]),
            .dec      (dchain[i]),
            .q        (digits[4*i +: 4]),
            .borrow   (dchain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            st      <= IDLE;
            presc   <= '0;
            running <= 1'b0;
            alarm   <= 1'b0;
`ifdef BCD_COUNTDOWN_ALARM_TIMEOUT_EN
            acnt    <= '0;
`endif
        end else begin
            case (st)
                IDLE: begin
                    if (!clear && !load && start && digits != 16'h0000) begin
                        st      <= RUN;
                        presc   <= '0;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (clear) begin
                        st      <= IDLE;
                        presc   <= '0;
                        running <= 1'b0;
                    end else if (tick && last_sec) begin
                        st      <= ALARM;
                        running <= 1'b0;
                        alarm   <= 1'b1;
`ifdef BCD_COUNTDOWN_ALARM_TIMEOUT_EN
                        acnt    <= '0;
`endif
                    end else if (pause) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (clear) begin
                        st    <= IDLE;
                        presc <= '0;
                    end else if (pause) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end
                end
                ALARM: begin
                    if (clear || start) begin
                        st    <= IDLE;
                        alarm <= 1'b0;
                    end
`ifdef BCD_COUNTDOWN_ALARM_TIMEOUT_EN
                    else begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (acnt == ALARM_LAST) begin
                                st    <= IDLE;
                                alarm <= 1'b0;
                            end else begin
                                acnt <= acnt + 1'b1;
                            end
                        end
                    end
`endif
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed bench for bcd_countdown_ctrl with a seconds-level reference model.
// Honours BCD_COUNTDOWN_ALARM_TIMEOUT_EN for the alarm timeout case.
module tb_bcd_countdown_ctrl;

    localparam int TD = 4;
    localparam int AS = 2;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        load = 1'b0;
    logic [15:0] set_value = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        alarm;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    int m_state = 0;
    int m_secs  = 0;
    int m_phase = 0;
    int m_acnt  = 0;

    bcd_countdown_ctrl #(.TICK_DIV(TD), .ALARM_SEC(AS)) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .load      (load),
        .set_value (set_value),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .digits    (digits),
        .running   (running),
        .alarm     (alarm),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic int clampi(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int preset_secs(logic [15:0] v);
        int mins;
        int secs;
        mins = clampi(int'(v[15:12]), 5) * 10 + clampi(int'(v[11:8]), 9);
        secs = clampi(int'(v[7:4]), 5) * 10 + clampi(int'(v[3:0]), 9);
        return mins * 60 + secs;
    endfunction

    function automatic logic [15:0] to_bcd(int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Reference model: remaining seconds plus a cycle phase within the second.
    always @(posedge clk) begin
        bit tk;
        if (reset_p) begin
            m_state = 0; m_secs = 0; m_phase = 0; m_acnt = 0;
        end else begin
            case (m_state)
                0: begin
                    if (clear) m_secs = 0;
                    else if (load) m_secs = preset_secs(set_value);
                    else if (start && m_secs != 0) begin
                        m_state = 1; m_phase = 0;
                    end
                end
                1: begin
                    tk = (m_phase == TD - 1);
                    m_phase = tk ? 0 : m_phase + 1;
                    if (clear) begin
                        m_state = 0; m_secs = 0; m_phase = 0;
                    end else begin
                        if (tk) m_secs = m_secs - 1;
                        if (tk && m_secs == 0) begin
                            m_state = 3; m_acnt = 0;
                        end else if (pause) m_state = 2;
                    end
                end
                2: begin
                    if (clear) begin
                        m_state = 0; m_secs = 0; m_phase = 0;
                    end else if (pause) m_state = 1;
                end
                default: begin
                    if (start || clear) m_state = 0;
`ifdef BCD_COUNTDOWN_ALARM_TIMEOUT_EN
                    else begin
                        tk = (m_phase == TD - 1);
                        m_phase = tk ? 0 : m_phase + 1;
                        if (tk) begin
                            m_acnt = m_acnt + 1;
                            if (m_acnt == AS) m_state = 0;
                        end
                    end
`endif
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [15:0] ed;
            ed = to_bcd(m_secs);
            checks++;
            if (digits !== ed || state !== 2'(m_state) ||
                running !== (m_state == 1) || alarm !== (m_state == 3)) begin
                failures++;
                $display("FAIL model t=%0t dig=%h/%h st=%0d/%0d run=%b al=%b",
                         $time, digits, ed, state, m_state, running, alarm);
            end
        end
    end

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmd(bit l, bit s, bit p, bit c, logic [15:0] v);
        load = l; start = s; pause = p; clear = c; set_value = v;
        @(negedge clk);
        load = 0; start = 0; pause = 0; clear = 0;
    endtask

    initial begin
        idle(2);
        reset_p = 1'b0;
        chk("reset_digits", digits, 16'h0000);
        chk("reset_state", 16'(state), 16'd0);
        cmp_en = 1'b1;

        cmd(1, 0, 0, 0, 16'h0105);
        chk("load_0105", digits, 16'h0105);
        cmd(0, 1, 0, 0, 16'h0000);
        chk("start_run", 16'(running), 16'd1);
        idle(3);
        chk("s3_digits", digits, 16'h0105);
        idle(1);
        chk("s4_digits", digits, 16'h0104);
        idle(16);
        chk("s20_digits", digits, 16'h0100);
        idle(4);
        chk("s24_digits", digits, 16'h0059);
        idle(235);
        chk("s259_alarm", 16'(alarm), 16'd0);
        idle(1);
        chk("s260_alarm", 16'(alarm), 16'd1);
        chk("s260_state", 16'(state), 16'd3);
        cmd(0, 0, 1, 0, 16'h0000);
        chk("alarm_pause", 16'(state), 16'd3);
        cmd(0, 1, 0, 0, 16'h0000);
        chk("alarm_start", 16'(state), 16'd0);

        cmd(1, 0, 0, 0, 16'h7A9F);
        chk("sanitize", digits, 16'h5959);
        cmd(0, 0, 0, 1, 16'h0000);
        chk("clear_idle", digits, 16'h0000);
        cmd(0, 1, 0, 0, 16'h0000);
        chk("start_zero", 16'(state), 16'd0);
        cmd(1, 1, 0, 0, 16'h0004);
        chk("load_over_start", 16'(state), 16'd0);

        cmd(1, 0, 0, 0, 16'h0003);
        cmd(0, 1, 0, 0, 16'h0000);
        idle(1);
        cmd(0, 0, 1, 0, 16'h0000);
        chk("paused", 16'(state), 16'd2);
        idle(9);
        cmd(0, 0, 1, 0, 16'h0000);
        chk("resumed", 16'(state), 16'd1);
        idle(9);
        chk("p21_alarm", 16'(alarm), 16'd0);
        idle(1);
        chk("p22_alarm", 16'(alarm), 16'd1);
`ifdef BCD_COUNTDOWN_ALARM_TIMEOUT_EN
        idle(7);
        chk("to7_alarm", 16'(alarm), 16'd1);
        idle(1);
        chk("to8_alarm", 16'(alarm), 16'd0);
        chk("to8_state", 16'(state), 16'd0);
`else
        idle(100);
        chk("hold_alarm", 16'(alarm), 16'd1);
        chk("hold_state", 16'(state), 16'd3);
        cmd(0, 0, 0, 1, 16'h0000);
        chk("alarm_clear", 16'(state), 16'd0);
`endif

        cmd(1, 0, 0, 0, 16'h0002);
        cmd(0, 1, 0, 0, 16'h0000);
        idle(1);
        cmd(0, 0, 1, 1, 16'h0000);
        chk("clr_pause_st", 16'(state), 16'd0);
        chk("clr_pause_dig", digits, 16'h0000);

        cmd(1, 0, 0, 0, 16'h0002);
        cmd(0, 1, 0, 0, 16'h0000);
        idle(3);
        cmd(0, 0, 0, 1, 16'h0000);
        chk("tick_clear", digits, 16'h0000);

        cmd(1, 0, 0, 0, 16'h0005);
        cmd(0, 1, 0, 0, 16'h0000);
        idle(3);
        cmd(0, 0, 1, 0, 16'h0000);
        chk("tick_pause_dig", digits, 16'h0004);
        chk("tick_pause_st", 16'(state), 16'd2);
        cmd(0, 0, 0, 1, 16'h0000);

        cmd(1, 0, 0, 0, 16'h1000);
        cmd(0, 1, 0, 0, 16'h0000);
        idle(3);
        cmd(0, 0, 0, 0, 16'h0000);
        chk("borrow_chain", digits, 16'h0959);
        cmd(0, 0, 0, 1, 16'h0000);

        cmd(1, 0, 0, 0, 16'h0007);
        cmd(0, 1, 0, 0, 16'h0000);
        idle(1);
        chk("pre_rst_dig", digits, 16'h0007);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        chk("rst_dig", digits, 16'h0000);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_run", 16'(running), 16'd0);
        chk("rst_alarm", 16'(alarm), 16'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
